// File: rtl/dpi_stream_sequencer.sv
// dpi_stream_sequencer
//
// Packet sequencer in front of one regex-matcher wrapper. For each packet it
// strobes a state restore, waits for the restored state to settle, forwards
// the payload bytes one cycle delayed, drains the matcher pipeline and then
// strobes end-of-packet with the per-stream enable. It also keeps the
// first-seen bitmap (new_stream_id) and the per-stream enable mask.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_vld/in_rdy/in_data   byte stream handshake and payload
//   in_sop/in_eop/in_sid    packet framing; in_sid sampled on the SOP byte
//   cfg_we/cfg_sid/cfg_enable  enable-mask bit write
//   clear_seen              clear the whole first-seen bitmap
//   m_load_state            one-cycle state-restore strobe
//   m_new_stream_id         stream not seen since reset/clear (with m_load_state)
//   m_stream_id, m_enable   current stream and its enable-mask bit
//   m_char_in/_vld          registered payload byte and valid
//   m_eop                   one-cycle end-of-packet strobe
//   busy, pkt_done, pkt_count, err_pulse  status

module dpi_stream_sequencer #(
    parameter int unsigned SID_W         = 6,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned DRAIN_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [7:0]       in_data,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [SID_W-1:0] in_sid,
    input  logic             cfg_we,
    input  logic [SID_W-1:0] cfg_sid,
    input  logic             cfg_enable,
    input  logic             clear_seen,
    output logic             m_load_state,
    output logic             m_new_stream_id,
    output logic [SID_W-1:0] m_stream_id,
    output logic             m_enable,
    output logic [7:0]       m_char_in,
    output logic             m_char_in_vld,
    output logic             m_eop,
    output logic             busy,
    output logic             pkt_done,
    output logic [15:0]      pkt_count,
    output logic             err_pulse
);

    localparam int unsigned NUM_STREAMS = 1 << SID_W;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StLoad   = 3'd1;
    localparam logic [2:0] StSettle = 3'd2;
    localparam logic [2:0] StStream = 3'd3;
    localparam logic [2:0] StDrain  = 3'd4;
    localparam logic [2:0] StEop    = 3'd5;

    // Shared wait counter for SETTLE and DRAIN; both counts must fit in 8 bits.
    localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] DrainLast  = 8'(DRAIN_CYCLES - 1);

    logic [2:0]             state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [SID_W-1:0]       sid_q, sid_d;
    logic                   first_q, first_d;
    logic [7:0]             char_q, char_d;
    logic                   char_vld_q, char_vld_d;
    logic                   err_q, err_d;
    logic [NUM_STREAMS-1:0] seen_q, seen_d;
    logic [NUM_STREAMS-1:0] mask_q, mask_d;
    logic [15:0]            pkt_count_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sid_d      = sid_q;
        first_d    = first_q;
        char_d     = char_q;
        char_vld_d = 1'b0;
        err_d      = 1'b0;
        in_rdy     = 1'b0;

        case (state_q)
            StIdle: begin
                if (in_vld) begin
                    if (in_sop) begin
                        // SOP byte stays pending; it is consumed later in STREAM.
                        sid_d   = in_sid;
                        state_d = StLoad;
                    end else begin
                        in_rdy = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            StLoad: begin
                cnt_d   = '0;
                first_d = 1'b1;
                state_d = StSettle;
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    state_d = StStream;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StStream: begin
                in_rdy = ~(in_sop & ~first_q);
                if (in_vld) begin
                    if (in_sop && !first_q) begin
                        // New SOP mid-packet: close this packet, replay the byte from IDLE.
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = StDrain;
                    end else begin
                        char_vld_d = 1'b1;
                        char_d     = in_data;
                        first_d    = 1'b0;
                        if (in_eop) begin
                            cnt_d   = '0;
                            state_d = StDrain;
                        end
                    end
                end
            end
            StDrain: begin
                if (cnt_q == DrainLast) begin
                    state_d = StEop;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StEop: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // The LOAD set of seen[sid] wins over a coincident clear for that index.
    always_comb begin
        seen_d = clear_seen ? '0 : seen_q;
        if (state_q == StLoad) begin
            seen_d[sid_q] = 1'b1;
        end
    end

    always_comb begin
        mask_d = mask_q;
        if (cfg_we) begin
            mask_d[cfg_sid] = cfg_enable;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sid_q       <= '0;
            first_q     <= 1'b0;
            char_q      <= '0;
            char_vld_q  <= 1'b0;
            err_q       <= 1'b0;
            seen_q      <= '0;
            mask_q      <= '1;
            pkt_count_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sid_q      <= sid_d;
            first_q    <= first_d;
            char_q     <= char_d;
            char_vld_q <= char_vld_d;
            err_q      <= err_d;
            seen_q     <= seen_d;
            mask_q     <= mask_d;
            if (state_q == StEop) begin
                pkt_count_q <= pkt_count_q + 16'd1;
            end
        end
    end

    assign m_load_state    = (state_q == StLoad);
    assign m_new_stream_id = m_load_state & ~seen_q[sid_q];
    assign m_stream_id     = sid_q;
    assign m_enable        = mask_q[sid_q];
    assign m_char_in       = char_q;
    assign m_char_in_vld   = char_vld_q;
    assign m_eop           = (state_q == StEop);
    assign pkt_done        = (state_q == StEop);
    assign busy            = (state_q != StIdle);
    assign pkt_count       = pkt_count_q;
    assign err_pulse       = err_q;

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
module tb_dpi_stream_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_vld;
    logic       in_rdy;
    logic [7:0] in_data;
    logic       in_sop;
    logic       in_eop;
    logic [5:0] in_sid;
    logic       cfg_we;
    logic [5:0] cfg_sid;
    logic       cfg_enable;
    logic       clear_seen;
    logic       m_load_state;
    logic       m_new_stream_id;
    logic [5:0] m_stream_id;
    logic       m_enable;
    logic [7:0] m_char_in;
    logic       m_char_in_vld;
    logic       m_eop;
    logic       busy;
    logic       pkt_done;
    logic [15:0] pkt_count;
    logic       err_pulse;

    dpi_stream_sequencer #(
        .SID_W(6),
        .SETTLE_CYCLES(1),
        .DRAIN_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_vld(in_vld),
        .in_rdy(in_rdy),
        .in_data(in_data),
        .in_sop(in_sop),
        .in_eop(in_eop),
        .in_sid(in_sid),
        .cfg_we(cfg_we),
        .cfg_sid(cfg_sid),
        .cfg_enable(cfg_enable),
        .clear_seen(clear_seen),
        .m_load_state(m_load_state),
        .m_new_stream_id(m_new_stream_id),
        .m_stream_id(m_stream_id),
        .m_enable(m_enable),
        .m_char_in(m_char_in),
        .m_char_in_vld(m_char_in_vld),
        .m_eop(m_eop),
        .busy(busy),
        .pkt_done(pkt_done),
        .pkt_count(pkt_count),
        .err_pulse(err_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    int n_load = 0, n_vld = 0, n_eop = 0, n_err = 0, n_new = 0, n_overlap = 0;
    logic       load_new;
    logic [5:0] load_sid;
    logic       eop_en;
    int         eop_cyc, last_vld_cyc;
    int         load_cyc_q[$];
    int         vld_cyc_q[$];
    int         eop_sid_q[$];
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_load_state) begin
                n_load++;
                load_new = m_new_stream_id;
                load_sid = m_stream_id;
                load_cyc_q.push_back(cyc);
                if (m_new_stream_id) n_new++;
                if (m_eop) n_overlap++;
            end
            if (m_char_in_vld) begin
                n_vld++;
                last_vld_cyc = cyc;
                vld_cyc_q.push_back(cyc);
                rx_q.push_back(m_char_in);
            end
            if (m_eop) begin
                n_eop++;
                eop_cyc = cyc;
                eop_en  = m_enable;
                eop_sid_q.push_back(int'(m_stream_id));
            end
            if (err_pulse) n_err++;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic clear_logs();
        load_cyc_q.delete();
        vld_cyc_q.delete();
        eop_sid_q.delete();
        rx_q.delete();
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the byte.
    task automatic send_byte(input logic [7:0] d, input logic sop, input logic eop,
                             input logic [5:0] sid);
        bit done;
        done    = 1'b0;
        in_vld  = 1'b1;
        in_data = d;
        in_sop  = sop;
        in_eop  = eop;
        in_sid  = sid;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (in_rdy) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_vld = 1'b0;
        in_sop = 1'b0;
        in_eop = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL send_byte: byte %0d not accepted, expected acceptance within 60 cycles", d);
        end
    endtask

    task automatic send_pkt(input logic [5:0] sid, input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            send_byte(base + 8'(i), i == 0, i == len - 1, sid);
        end
    endtask

    task automatic wait_eop(input int target);
        int i;
        i = 0;
        while (n_eop < target && i < 60) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (n_eop < target) begin
            n_checks++;
            $display("FAIL wait_eop: saw %0d m_eop, expected %0d", n_eop, target);
        end
    endtask

    task automatic cfg_on_eop(input logic [5:0] sid, input logic en);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (m_eop) begin
                cfg_we     = 1'b1;
                cfg_sid    = sid;
                cfg_enable = en;
                @(posedge clk);
                #1;
                cfg_we = 1'b0;
                done   = 1'b1;
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL cfg_on_eop: no m_eop seen, expected one within 60 cycles");
        end
    endtask

    task automatic cfg_write(input logic [5:0] sid, input logic en);
        cfg_we     = 1'b1;
        cfg_sid    = sid;
        cfg_enable = en;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [5:0] sid;
        int         len;
        logic [7:0] base;
        logic       exp_new;
        logic       exp_en;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int e0, l0, v0, r0, n0, bad;

        vecs[0] = '{sid: 6'd5, len: 3, base: 8'h10, exp_new: 1'b1, exp_en: 1'b1};
        vecs[1] = '{sid: 6'd5, len: 1, base: 8'h20, exp_new: 1'b0, exp_en: 1'b1};
        vecs[2] = '{sid: 6'd9, len: 2, base: 8'h30, exp_new: 1'b1, exp_en: 1'b1};
        vecs[3] = '{sid: 6'd9, len: 4, base: 8'h40, exp_new: 1'b0, exp_en: 1'b1};
        vecs[4] = '{sid: 6'd0, len: 1, base: 8'h50, exp_new: 1'b1, exp_en: 1'b1};

        rst_n = 1'b0; in_vld = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0;
        in_sid = '0; cfg_we = 1'b0; cfg_sid = '0; cfg_enable = 1'b0; clear_seen = 1'b0;
        do_reset();

        // Reset state
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset in_rdy", in_rdy, 0);
        check("reset m_load_state", m_load_state, 0);
        check("reset m_eop", m_eop, 0);
        check("reset m_char_in_vld", m_char_in_vld, 0);
        check("reset pkt_count", pkt_count, 0);
        check("reset err_pulse", err_pulse, 0);
        check("reset m_enable", m_enable, 1);
        @(posedge clk);
        #1;

        // Table-driven packets
        for (int i = 0; i < 5; i++) begin
            clear_logs();
            e0 = n_eop;
            send_pkt(vecs[i].sid, vecs[i].len, vecs[i].base);
            wait_eop(e0 + 1);
            bad = 0;
            for (int k = 0; k < rx_q.size(); k++) begin
                if (rx_q[k] !== vecs[i].base + 8'(k)) bad++;
            end
            check($sformatf("v%0d new_stream_id", i), load_new, vecs[i].exp_new);
            check($sformatf("v%0d stream_id", i), load_sid, vecs[i].sid);
            check($sformatf("v%0d byte count", i), rx_q.size(), vecs[i].len);
            check($sformatf("v%0d payload bad bytes", i), bad, 0);
            check($sformatf("v%0d first vld after load", i),
                  vld_cyc_q[0] - load_cyc_q[0], 3);
            check($sformatf("v%0d eop after last vld", i), eop_cyc - last_vld_cyc, 2);
            check($sformatf("v%0d eop enable", i), eop_en, vecs[i].exp_en);
            check($sformatf("v%0d pkt_count", i), pkt_count, i + 1);
        end

        // clear_seen makes sid 5 new again
        clear_seen = 1'b1;
        @(posedge clk);
        #1;
        clear_seen = 1'b0;
        e0 = n_eop;
        send_pkt(6'd5, 1, 8'h60);
        wait_eop(e0 + 1);
        check("after clear new_stream_id", load_new, 1);

        // Enable mask: cleared before EOP, then a write during EOP is not seen
        cfg_write(6'd5, 1'b0);
        e0 = n_eop;
        send_pkt(6'd5, 2, 8'h70);
        wait_eop(e0 + 1);
        check("disabled eop enable", eop_en, 0);
        e0 = n_eop;
        fork
            send_pkt(6'd5, 1, 8'h78);
            cfg_on_eop(6'd5, 1'b1);
        join
        wait_eop(e0 + 1);
        check("write during eop enable", eop_en, 0);
        e0 = n_eop;
        send_pkt(6'd5, 1, 8'h7c);
        wait_eop(e0 + 1);
        check("re-enabled eop enable", eop_en, 1);

        // Non-SOP byte in IDLE is dropped with an error
        l0 = n_load; r0 = n_err; v0 = n_vld;
        send_byte(8'h77, 1'b0, 1'b0, 6'd0);
        repeat (3) @(posedge clk);
        #1;
        check("idle nonsop err", n_err - r0, 1);
        check("idle nonsop no load", n_load - l0, 0);
        check("idle nonsop no vld", n_vld - v0, 0);
        check("idle nonsop busy", busy, 0);

        // SOP mid-packet: old packet closes, new one restarts with that byte
        clear_logs();
        e0 = n_eop; r0 = n_err;
        send_byte(8'ha0, 1'b1, 1'b0, 6'd3);
        send_byte(8'ha1, 1'b0, 1'b0, 6'd3);
        send_byte(8'hb0, 1'b1, 1'b1, 6'd7);
        wait_eop(e0 + 2);
        check("mid sop err", n_err - r0, 1);
        check("mid sop eop count", eop_sid_q.size(), 2);
        check("mid sop first eop sid", eop_sid_q[0], 3);
        check("mid sop second eop sid", eop_sid_q[1], 7);
        check("mid sop new load sid", load_sid, 7);
        check("mid sop new load new", load_new, 1);
        check("mid sop byte count", rx_q.size(), 3);
        check("mid sop replayed byte", rx_q[2], 8'hb0);

        // Back-to-back one-byte packets on every stream
        do_reset();
        clear_logs();
        e0 = n_eop; n0 = n_new;
        for (int s = 0; s < 64; s++) begin
            send_byte(8'(s), 1'b1, 1'b1, 6'(s));
        end
        wait_eop(e0 + 64);
        bad = 0;
        for (int k = 1; k < load_cyc_q.size(); k++) begin
            if (load_cyc_q[k] - load_cyc_q[k-1] != 7) bad++;
        end
        check("b2b new ids", n_new - n0, 64);
        check("b2b loads", load_cyc_q.size(), 64);
        check("b2b period violations", bad, 0);
        check("b2b pkt_count", pkt_count, 64);
        check("b2b last byte", rx_q[63], 8'd63);
        check("load/eop overlap", n_overlap, 0);

        // pkt_count wrap
        force dut.pkt_count_q = 16'hffff;
        @(posedge clk);
        #1;
        release dut.pkt_count_q;
        e0 = n_eop;
        send_pkt(6'd1, 1, 8'h90);
        wait_eop(e0 + 1);
        check("pkt_count wrap", pkt_count, 0);

        // Reset in STREAM abandons the packet
        cfg_write(6'd12, 1'b0);
        e0 = n_eop;
        send_byte(8'hc0, 1'b1, 1'b0, 6'd12);
        send_byte(8'hc1, 1'b0, 1'b0, 6'd12);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst busy", busy, 0);
        check("rst m_char_in_vld", m_char_in_vld, 0);
        check("rst m_eop", m_eop, 0);
        check("rst m_load_state", m_load_state, 0);
        check("rst pkt_count", pkt_count, 0);
        check("rst m_stream_id", m_stream_id, 0);
        repeat (8) @(posedge clk);
        #1;
        check("rst no eop", n_eop - e0, 0);
        send_pkt(6'd12, 1, 8'hd0);
        wait_eop(e0 + 1);
        check("rst new_stream_id", load_new, 1);
        check("rst mask restored", eop_en, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
